ps2_mouse_ctrl: RTL and testbench



---
 rtl/ps2_pkg.sv | 28 ++
 rtl/ps2_mouse_ctrl_edge_pulse.sv | 25 ++
 rtl/ps2_mouse_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_ps2_mouse_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 mouse protocol constants and controller state encoding.
package ps2_pkg;

  // Host-to-mouse commands
  localparam logic [7:0] CMD_RESET  = 8'hFF;
  localparam logic [7:0] CMD_ENABLE = 8'hF4;

  // Mouse-to-host responses
  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK = 8'hAA;
  localparam logic [7:0] RSP_ERROR  = 8'hFC;
  localparam logic [7:0] MOUSE_ID   = 8'h00;

  typedef enum logic [3:0] {
    ST_SEND_RST  = 4'd0,
    ST_WAIT_ACK1 = 4'd1,
    ST_WAIT_BAT  = 4'd2,
    ST_WAIT_ID   = 4'd3,
    ST_SEND_EN   = 4'd4,
    ST_WAIT_ACK2 = 4'd5,
    ST_STREAM_B0 = 4'd6,
    ST_STREAM_B1 = 4'd7,
    ST_STREAM_B2 = 4'd8,
    ST_FAIL      = 4'd9
  } state_t;

endpackage

// File: rtl/ps2_mouse_ctrl_edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse, one clock after the input edge.
module ps2_edge_pulse (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;
  logic pulse_q;

  // Delay the input and register the 0->1 comparison
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sig_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sig_q   <= sig_i;
      pulse_q <= sig_i & ~sig_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse protocol controller: init handshake, then 3-byte packet assembly.
module ps2_mouse_ctrl #(
  parameter int unsigned PKT_TIMEOUT  = 200000,
  parameter int unsigned RESP_TIMEOUT = 50000000,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_error,
  output logic [7:0] tx_data,
  output logic       tx_enable,
  input  logic       tx_busy,
  input  logic       tx_complete,
  output logic       init_done,
  output logic       init_fail,
  output logic       packet_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic       x_ovf,
  output logic       y_ovf
);

  import ps2_pkg::*;

  localparam int unsigned TMR_MAX = (PKT_TIMEOUT > RESP_TIMEOUT) ? PKT_TIMEOUT : RESP_TIMEOUT;
  localparam int unsigned TW      = $clog2(TMR_MAX + 1);
  localparam int unsigned RW      = $clog2(MAX_RETRY + 1);

  state_t          state_q, state_d;
  logic            sent_q, sent_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmr_q;
  logic            tx_en_q;
  logic [7:0]      tx_data_q;
  logic [7:0]      rx_byte_q;
  logic            rx_err_q;
  logic            byte_ev;
  logic            done_ev;
  logic            init_fault;
  logic            pkt_load;
  logic            tmr_run;
  logic            resp_expired;
  logic            gap_expired;
  // First packet byte without the sync bit: {y_ovf, x_ovf, y_sign, x_sign, mid, right, left}
  logic [6:0]      b0_q;
  logic [7:0]      b1_q;
  logic [2:0]      btn_q;
  logic [8:0]      dx_q, dy_q;
  logic            xovf_q, yovf_q, pv_q;

  ps2_edge_pulse u_rx_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .sig_i   (rx_valid),
    .pulse_o (byte_ev)
  );

  ps2_edge_pulse u_tx_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .sig_i   (tx_complete),
    .pulse_o (done_ev)
  );

  assign resp_expired = (tmr_q >= TW'(RESP_TIMEOUT));
  assign gap_expired  = (tmr_q >= TW'(PKT_TIMEOUT));
  assign tmr_run      = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_BAT) ||
                        (state_q == ST_WAIT_ID)   || (state_q == ST_WAIT_ACK2) ||
                        (state_q == ST_STREAM_B1) || (state_q == ST_STREAM_B2);

  // State register with send-handshake progress and retry count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_SEND_RST;
      sent_q  <= 1'b0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      retry_q <= retry_d;
    end
  end

  // Next-state logic; a received byte always takes precedence over a timeout
  always_comb begin
    state_d    = state_q;
    sent_d     = sent_q;
    retry_d    = retry_q;
    init_fault = 1'b0;
    pkt_load   = 1'b0;
    case (state_q)
      ST_SEND_RST, ST_SEND_EN: begin
        if (tx_en_q && tx_busy) sent_d = 1'b1;
        if (done_ev && sent_q)
          state_d = (state_q == ST_SEND_RST) ? ST_WAIT_ACK1 : ST_WAIT_ACK2;
        else if (byte_ev)
          // Transmitter turned around to receive: drop the byte and send again
          sent_d = 1'b0;
      end
      ST_WAIT_ACK1, ST_WAIT_ACK2: begin
        if (byte_ev) begin
          if (!rx_err_q && rx_byte_q == RSP_ACK)
            state_d = (state_q == ST_WAIT_ACK1) ? ST_WAIT_BAT : ST_STREAM_B0;
          else if (!rx_err_q && rx_byte_q == RSP_RESEND)
            state_d = (state_q == ST_WAIT_ACK1) ? ST_SEND_RST : ST_SEND_EN;
          else
            init_fault = 1'b1;
        end else if (resp_expired) begin
          init_fault = 1'b1;
        end
      end
      ST_WAIT_BAT, ST_WAIT_ID: begin
        if (byte_ev) begin
          if (!rx_err_q && state_q == ST_WAIT_BAT && rx_byte_q == RSP_BAT_OK)
            state_d = ST_WAIT_ID;
          else if (!rx_err_q && state_q == ST_WAIT_ID && rx_byte_q == MOUSE_ID)
            state_d = ST_SEND_EN;
          else
            init_fault = 1'b1;
        end else if (resp_expired) begin
          init_fault = 1'b1;
        end
      end
      ST_STREAM_B0: begin
        if (byte_ev && !rx_err_q && rx_byte_q[3]) state_d = ST_STREAM_B1;
      end
      ST_STREAM_B1: begin
        if (byte_ev) state_d = rx_err_q ? ST_STREAM_B0 : ST_STREAM_B2;
        else if (gap_expired) state_d = ST_STREAM_B0;
      end
      ST_STREAM_B2: begin
        if (byte_ev) begin
          pkt_load = ~rx_err_q;
          state_d  = ST_STREAM_B0;
        end else if (gap_expired) begin
          state_d = ST_STREAM_B0;
        end
      end
      default: ;
    endcase
    if (init_fault) begin
      retry_d = retry_q + RW'(1);
      state_d = (retry_d >= RW'(MAX_RETRY)) ? ST_FAIL : ST_SEND_RST;
    end
    if (state_d != state_q) sent_d = 1'b0;
  end

  // Output decode from current state
  always_comb begin
    tx_data   = tx_data_q;
    tx_enable = tx_en_q & ~tx_busy;
    init_done = (state_q == ST_STREAM_B0) || (state_q == ST_STREAM_B1) ||
                (state_q == ST_STREAM_B2);
    init_fail = (state_q == ST_FAIL);
  end

  // Datapath: timers, send request, byte capture and packet output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q     <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      rx_byte_q <= '0;
      rx_err_q  <= 1'b0;
      b0_q      <= '0;
      b1_q      <= '0;
      btn_q     <= '0;
      dx_q      <= '0;
      dy_q      <= '0;
      xovf_q    <= 1'b0;
      yovf_q    <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      rx_byte_q <= rx_data;
      rx_err_q  <= rx_error;
      tx_en_q   <= ((state_d == ST_SEND_RST) || (state_d == ST_SEND_EN)) && !sent_d;
      if (state_d == ST_SEND_RST)     tx_data_q <= CMD_RESET;
      else if (state_d == ST_SEND_EN) tx_data_q <= CMD_ENABLE;
      if (state_d != state_q)         tmr_q <= '0;
      else if (tmr_run && tmr_q != '1) tmr_q <= tmr_q + TW'(1);
      if (state_q == ST_STREAM_B0 && state_d == ST_STREAM_B1)
        b0_q <= {rx_byte_q[7:4], rx_byte_q[2:0]};
      if (state_q == ST_STREAM_B1 && state_d == ST_STREAM_B2)
        b1_q <= rx_byte_q;
      pv_q <= pkt_load;
      if (pkt_load) begin
        btn_q  <= b0_q[2:0];
        dx_q   <= {b0_q[3], b1_q};
        dy_q   <= {b0_q[4], rx_byte_q};
        xovf_q <= b0_q[5];
        yovf_q <= b0_q[6];
      end
    end
  end

  assign packet_valid = pv_q;
  assign btn_left     = btn_q[0];
  assign btn_right    = btn_q[1];
  assign btn_middle   = btn_q[2];
  assign dx           = dx_q;
  assign dy           = dy_q;
  assign x_ovf        = xovf_q;
  assign y_ovf        = yovf_q;

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Bench for ps2_mouse_ctrl: acts as the transmitter and mouse, scoreboards commands and packets.
module tb_ps2_mouse_ctrl;

  localparam int unsigned PKT_TO  = 200;
  localparam int unsigned RESP_TO = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid, rx_error;
  logic [7:0] tx_data;
  logic       tx_enable, tx_busy, tx_complete;
  logic       init_done, init_fail, packet_valid;
  logic       btn_left, btn_right, btn_middle;
  logic [8:0] dx, dy;
  logic       x_ovf, y_ovf;

  typedef struct packed {
    logic [2:0] btn;   // {middle, right, left}
    logic [8:0] dx;
    logic [8:0] dy;
    logic [1:0] ovf;   // {y, x}
  } pkt_t;

  pkt_t       exp_pkt_q[$];
  logic [7:0] exp_cmd_q[$];
  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  ps2_mouse_ctrl #(
    .PKT_TIMEOUT  (PKT_TO),
    .RESP_TIMEOUT (RESP_TO),
    .MAX_RETRY    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_error     (rx_error),
    .tx_data      (tx_data),
    .tx_enable    (tx_enable),
    .tx_busy      (tx_busy),
    .tx_complete  (tx_complete),
    .init_done    (init_done),
    .init_fail    (init_fail),
    .packet_valid (packet_valid),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_middle   (btn_middle),
    .dx           (dx),
    .dy           (dy),
    .x_ovf        (x_ovf),
    .y_ovf        (y_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Packet scoreboard: every packet_valid cycle pops one expected packet
  always @(negedge clk) begin
    if (rst === 1'b0 && packet_valid === 1'b1) begin
      if (exp_pkt_q.size() == 0) begin
        check_eq("pkt_unexpected", 32'd1, 32'd0);
      end else begin
        pkt_t e;
        e = exp_pkt_q.pop_front();
        check_eq("pkt_btn", {29'd0, btn_middle, btn_right, btn_left}, {29'd0, e.btn});
        check_eq("pkt_dx",  {23'd0, dx}, {23'd0, e.dx});
        check_eq("pkt_dy",  {23'd0, dy}, {23'd0, e.dy});
        check_eq("pkt_ovf", {30'd0, y_ovf, x_ovf}, {30'd0, e.ovf});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_error = 1'b0;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Wait for a send request, compare it with the next expected command, then play transmitter
  task automatic serve_cmd(input string tag);
    int unsigned n = 0;
    logic [7:0] e = 8'h00;
    while (tx_enable !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (exp_cmd_q.size() != 0) e = exp_cmd_q.pop_front();
    if (tx_enable !== 1'b1) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq(tag, {24'd0, tx_data}, {24'd0, e});
    tx_busy = 1'b1;
    @(negedge clk);
    check_eq({tag, "_en_drop"}, {31'd0, tx_enable}, 32'd0);
    repeat (4) @(negedge clk);
    tx_busy = 1'b0;
    @(negedge clk);
    check_eq({tag, "_en_idle"}, {31'd0, tx_enable}, 32'd0);
    tx_complete = 1'b1;
    repeat (2) @(negedge clk);
    tx_complete = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n_en;
    rst         = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    rx_error    = 1'b0;
    tx_busy     = 1'b0;
    tx_complete = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_tx",    {23'd0, tx_enable, tx_data}, 32'd0);
    check_eq("rst_flags", {29'd0, init_done, init_fail, packet_valid}, 32'd0);
    check_eq("rst_pkt",   {7'd0, btn_middle, btn_right, btn_left, dx, dy, y_ovf, x_ovf}, 32'd0);
    rst = 1'b0;

    // Nominal bring-up
    exp_cmd_q.push_back(8'hFF);
    serve_cmd("cmd_reset");
    send_byte(8'hFA);
    send_byte(8'hAA);
    send_byte(8'h00);
    exp_cmd_q.push_back(8'hF4);
    serve_cmd("cmd_enable");
    check_eq("pre_init_done", {31'd0, init_done}, 32'd0);
    send_byte(8'hFA);
    check_eq("init_done", {31'd0, init_done}, 32'd1);
    check_eq("init_fail_nom", {31'd0, init_fail}, 32'd0);

    // Packet with negative dx
    exp_pkt_q.push_back('{btn: 3'b001, dx: 9'h105, dy: 9'h0FB, ovf: 2'b00});
    send_byte(8'h19); send_byte(8'h05); send_byte(8'hFB);
    repeat (5) @(negedge clk);
    check_eq("dx_hold", {23'd0, dx}, 32'h105);

    // Resync: byte without bit3 is dropped
    exp_pkt_q.push_back('{btn: 3'b000, dx: 9'h010, dy: 9'h020, ovf: 2'b00});
    send_byte(8'h00); send_byte(8'h08); send_byte(8'h10); send_byte(8'h20);

    // Overflow flags and sign bits, all buttons
    exp_pkt_q.push_back('{btn: 3'b111, dx: 9'h1FF, dy: 9'h180, ovf: 2'b11});
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h80);

    // Gap timeout discards the partial packet
    exp_pkt_q.push_back('{btn: 3'b001, dx: 9'h002, dy: 9'h003, ovf: 2'b00});
    send_byte(8'h08); send_byte(8'h01);
    repeat (2 * PKT_TO) @(negedge clk);
    send_byte(8'h09); send_byte(8'h02); send_byte(8'h03);
    repeat (5) @(negedge clk);
    check_eq("pkt_missing", exp_pkt_q.size(), 32'd0);

    // Resend request repeats FF once, then init completes
    pulse_reset();
    exp_cmd_q.push_back(8'hFF);
    serve_cmd("cmd_reset_1st");
    send_byte(8'hFE);
    exp_cmd_q.push_back(8'hFF);
    serve_cmd("cmd_reset_2nd");
    send_byte(8'hFA); send_byte(8'hAA); send_byte(8'h00);
    exp_cmd_q.push_back(8'hF4);
    serve_cmd("cmd_enable_rs");
    send_byte(8'hFA);
    check_eq("init_done_rs", {31'd0, init_done}, 32'd1);

    // Silent mouse: three attempts then terminal failure
    pulse_reset();
    for (int unsigned i = 0; i < 3; i++) begin
      exp_cmd_q.push_back(8'hFF);
      serve_cmd("cmd_retry");
    end
    n_en = 0;
    repeat (3 * RESP_TO) begin
      @(negedge clk);
      if (tx_enable !== 1'b0) n_en++;
    end
    check_eq("fail_tx_quiet", n_en, 32'd0);
    check_eq("init_fail", {31'd0, init_fail}, 32'd1);
    check_eq("init_done_fail", {31'd0, init_done}, 32'd0);
    send_byte(8'hFA);
    check_eq("fail_sticky", {30'd0, init_fail, tx_enable}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
